// File: rtl/y_mux_rr_pkg.sv
// Shared constants for the registered N:1 mux: mode encodings and grant-counter width.
// Optional grant counters are enabled by defining Y_MUX_CNT_EN.
package y_mux_rr_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int CNT_W      = 16;

    // Channel-index width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/y_mux_rr_arb.sv
// Combinational round-robin picker: the first requester at or after ptr (mod N) wins.
// Also used by y_mux_rr when MODE selects round-robin arbitration.
module y_rr_arb
    import y_mux_rr_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [SELW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = SELW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/y_mux_rr.sv
// N-channel W-bit registered mux with valid/ready on every channel and on the output.
// Define Y_MUX_CNT_EN to add per-channel saturating grant counters (cnt_sel/cnt_out ports).
module y_mux_rr
    import y_mux_rr_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int N    = 4,
    parameter  int MODE = MODE_FIXED,
    localparam int SELW = sel_width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
`ifdef Y_MUX_CNT_EN
    input  logic [SELW-1:0]   cnt_sel,
    output logic [CNT_W-1:0]  cnt_out,
`endif
    input  logic              out_ready
);

    logic [N-1:0]    grant;
    logic [SELW-1:0] win_idx;
    logic            win_any;
    logic [W-1:0]    win_data;
    logic            load;
    logic            xfer;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_chan_q,  out_chan_d;

    assign load     = ~out_valid_q | out_ready;
    assign xfer     = load & win_any;
    assign in_ready = {N{load}} & grant;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] ptr_q, ptr_d;
            logic            sel_unused;

            assign sel_unused = ^sel;

            y_rr_arb #(.N(N), .SELW(SELW)) u_arb (
                .req   (in_valid),
                .ptr   (ptr_q),
                .grant (grant),
                .idx   (win_idx),
                .any   (win_any)
            );

            // Pointer moves only on a transfer, so stalls never skip a channel.
            always_comb begin
                ptr_d = ptr_q;
                if (xfer)
                    ptr_d = (win_idx == SELW'(N - 1)) ? '0 : win_idx + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ptr_q <= '0;
                else        ptr_q <= ptr_d;
            end
        end else begin : g_fixed
            always_comb begin
                grant = '0;
                if (int'(sel) < N)
                    grant[sel] = in_valid[sel];
            end
            assign win_idx = sel;
            assign win_any = |grant;
        end
    endgenerate

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) win_data = in_data[i*W +: W];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = win_data;
                out_chan_d = win_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef Y_MUX_CNT_EN
    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++)
            if (xfer && grant[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_out = (int'(cnt_sel) < N) ? cnt_q[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_y_mux_rr.sv
// Self-checking bench: fixed-select (N=4 and N=3) and round-robin (N=4) instances, W=8.
module tb_y_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0] u0_rdy, u1_rdy;
    logic [7:0] u0_data, u1_data;
    logic [1:0] u0_chan, u1_chan;
    logic       u0_vld, u1_vld;

    logic [23:0] d2;
    logic [2:0]  v2, u2_rdy;
    logic [1:0]  sel2, u2_chan;
    logic [7:0]  u2_data;
    logic        u2_vld, rdy2;

`ifdef Y_MUX_CNT_EN
    logic [1:0]  cs0, cs1, cs2;
    logic [15:0] cnt0, cnt1, cnt2;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    y_mux_rr #(.W(8), .N(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(u0_rdy),
        .sel(sel), .out_data(u0_data), .out_chan(u0_chan), .out_valid(u0_vld),
`ifdef Y_MUX_CNT_EN
        .cnt_sel(cs0), .cnt_out(cnt0),
`endif
        .out_ready(out_ready)
    );

    y_mux_rr #(.W(8), .N(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(u1_rdy),
        .sel(sel), .out_data(u1_data), .out_chan(u1_chan), .out_valid(u1_vld),
`ifdef Y_MUX_CNT_EN
        .cnt_sel(cs1), .cnt_out(cnt1),
`endif
        .out_ready(out_ready)
    );

    y_mux_rr #(.W(8), .N(3), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(u2_rdy),
        .sel(sel2), .out_data(u2_data), .out_chan(u2_chan), .out_valid(u2_vld),
`ifdef Y_MUX_CNT_EN
        .cnt_sel(cs2), .cnt_out(cnt2),
`endif
        .out_ready(rdy2)
    );

    // Reference model: output register contents plus round-robin "next preferred" channel.
    logic       m0_v, m1_v, n0_v, n1_v;
    logic [7:0] m0_d, m1_d, n0_d, n1_d;
    int         m0_c, m1_c, n0_c, n1_c, m1_p, n1_p;
    logic [3:0] e_rdy0, e_rdy1;

    function automatic int pick_fixed(logic [3:0] v, logic [1:0] s);
        return v[s] ? int'(s) : -1;
    endfunction

    // Valid channel closest to p going upward with wraparound.
    function automatic int pick_rr(logic [3:0] v, int p);
        int best = -1;
        int bd   = 4;
        for (int i = 0; i < 4; i++)
            if (v[i] && ((i - p + 4) % 4) < bd) begin
                bd   = (i - p + 4) % 4;
                best = i;
            end
        return best;
    endfunction

    task automatic model_pre();
        int  w;
        bit  ld;
        ld = !m0_v || out_ready;
        w  = pick_fixed(in_valid, sel);
        e_rdy0 = '0; n0_v = m0_v; n0_d = m0_d; n0_c = m0_c;
        if (ld) begin
            n0_v = (w >= 0);
            if (w >= 0) begin e_rdy0[w] = 1'b1; n0_d = in_data[w*8 +: 8]; n0_c = w; end
        end
        ld = !m1_v || out_ready;
        w  = pick_rr(in_valid, m1_p);
        e_rdy1 = '0; n1_v = m1_v; n1_d = m1_d; n1_c = m1_c; n1_p = m1_p;
        if (ld) begin
            n1_v = (w >= 0);
            if (w >= 0) begin
                e_rdy1[w] = 1'b1; n1_d = in_data[w*8 +: 8]; n1_c = w; n1_p = (w + 1) % 4;
            end
        end
    endtask

    task automatic model_clk();
        m0_v = n0_v; m0_d = n0_d; m0_c = n0_c;
        m1_v = n1_v; m1_d = n1_d; m1_c = n1_c; m1_p = n1_p;
    endtask

    task automatic zero_inputs();
        in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b0;
        d2 = '0; v2 = '0; sel2 = '0; rdy2 = 1'b0;
`ifdef Y_MUX_CNT_EN
        cs0 = '0; cs1 = '0; cs2 = '0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m0_v = 0; m0_d = '0; m0_c = 0;
        m1_v = 0; m1_d = '0; m1_c = 0; m1_p = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        zero_inputs();
        #1;
        n_chk += 3;
        if (u0_vld !== 1'b0) $display("FAIL rst0_vld: got %0h want 0", u0_vld); else n_pass++;
        if (u0_data !== 8'h00) $display("FAIL rst0_data: got %0h want 0", u0_data); else n_pass++;
        if (u1_chan !== 2'd0) $display("FAIL rst0_chan: got %0h want 0", u1_chan); else n_pass++;
        do_reset();
        in_valid = 4'hF; sel = 2'd3; in_data = 32'hC3B2A191; out_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        #1;
        n_chk += 2;
        if (u0_vld !== 1'b1) $display("FAIL pre_rst_vld0: got %0h want 1", u0_vld); else n_pass++;
        if (u1_vld !== 1'b1) $display("FAIL pre_rst_vld1: got %0h want 1", u1_vld); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk += 6;
        if (u0_vld !== 1'b0) $display("FAIL midrst_vld0: got %0h want 0", u0_vld); else n_pass++;
        if (u0_data !== 8'h00) $display("FAIL midrst_data0: got %0h want 0", u0_data); else n_pass++;
        if (u0_chan !== 2'd0) $display("FAIL midrst_chan0: got %0h want 0", u0_chan); else n_pass++;
        if (u1_vld !== 1'b0) $display("FAIL midrst_vld1: got %0h want 0", u1_vld); else n_pass++;
        if (u1_data !== 8'h00) $display("FAIL midrst_data1: got %0h want 0", u1_data); else n_pass++;
        if (u1_chan !== 2'd0) $display("FAIL midrst_chan1: got %0h want 0", u1_chan); else n_pass++;
    endtask

    task automatic test_fixed();
        do_reset();
        sel = 2'd2; in_valid = 4'b0100; in_data = 32'h11A52233; out_ready = 1'b1;
        sel2 = 2'd3; v2 = 3'b111; d2 = 24'h5A6B7C; rdy2 = 1'b1;
        #1;
        n_chk += 2;
        if (u0_rdy !== 4'b0100) $display("FAIL fix_rdy: got %0h want 4", u0_rdy); else n_pass++;
        if (u2_rdy !== 3'b000) $display("FAIL sel_oob_rdy: got %0h want 0", u2_rdy); else n_pass++;
        @(posedge clk); #1;
        n_chk += 4;
        if (u0_data !== 8'hA5) $display("FAIL fix_data: got %0h want a5", u0_data); else n_pass++;
        if (u0_chan !== 2'd2) $display("FAIL fix_chan: got %0h want 2", u0_chan); else n_pass++;
        if (u0_vld !== 1'b1) $display("FAIL fix_vld: got %0h want 1", u0_vld); else n_pass++;
        if (u2_vld !== 1'b0) $display("FAIL sel_oob_vld: got %0h want 0", u2_vld); else n_pass++;
        sel = 2'd1; sel2 = 2'd2;
        #1;
        n_chk += 2;
        if (u0_rdy !== 4'b0000) $display("FAIL fix_inv_rdy: got %0h want 0", u0_rdy); else n_pass++;
        if (u2_rdy !== 3'b100) $display("FAIL n3_rdy: got %0h want 4", u2_rdy); else n_pass++;
        @(posedge clk); #1;
        n_chk += 5;
        if (u0_vld !== 1'b0) $display("FAIL fix_drop_vld: got %0h want 0", u0_vld); else n_pass++;
        if (u0_data !== 8'hA5) $display("FAIL fix_hold_data: got %0h want a5", u0_data); else n_pass++;
        if (u0_chan !== 2'd2) $display("FAIL fix_hold_chan: got %0h want 2", u0_chan); else n_pass++;
        if (u2_data !== 8'h5A) $display("FAIL n3_data: got %0h want 5a", u2_data); else n_pass++;
        if (u2_chan !== 2'd2) $display("FAIL n3_chan: got %0h want 2", u2_chan); else n_pass++;
    endtask

    task automatic test_rr_rotation();
        logic [3:0] exp_g;
        do_reset();
        in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1;
            n_chk++;
            if (u1_rdy !== exp_g) $display("FAIL rr_rdy[%0d]: got %0h want %0h", k, u1_rdy, exp_g); else n_pass++;
            @(posedge clk); #1;
            n_chk += 3;
            if (u1_chan !== 2'(k % 4)) $display("FAIL rr_chan[%0d]: got %0d want %0d", k, u1_chan, k % 4); else n_pass++;
            if (u1_data !== 8'(8'h10 + k % 4)) $display("FAIL rr_data[%0d]: got %0h want %0h", k, u1_data, 8'h10 + k % 4); else n_pass++;
            if (u1_vld !== 1'b1) $display("FAIL rr_vld[%0d]: got %0h want 1", k, u1_vld); else n_pass++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 4'hF; in_data = 32'h13121110; sel = 2'd0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = 2'($urandom); in_data = $urandom;
            #1;
            n_chk += 2;
            if (u1_rdy !== 4'b0000) $display("FAIL stall_rdy1[%0d]: got %0h want 0", k, u1_rdy); else n_pass++;
            if (u0_rdy !== 4'b0000) $display("FAIL stall_rdy0[%0d]: got %0h want 0", k, u0_rdy); else n_pass++;
            @(posedge clk); #1;
            n_chk += 5;
            if (u1_chan !== 2'd1) $display("FAIL stall_chan1[%0d]: got %0d want 1", k, u1_chan); else n_pass++;
            if (u1_data !== 8'h11) $display("FAIL stall_data1[%0d]: got %0h want 11", k, u1_data); else n_pass++;
            if (u1_vld !== 1'b1) $display("FAIL stall_vld1[%0d]: got %0h want 1", k, u1_vld); else n_pass++;
            if (u0_chan !== 2'd0) $display("FAIL stall_chan0[%0d]: got %0d want 0", k, u0_chan); else n_pass++;
            if (u0_data !== 8'h10) $display("FAIL stall_data0[%0d]: got %0h want 10", k, u0_data); else n_pass++;
        end
        out_ready = 1'b1; in_data = 32'h13121110;
        #1;
        n_chk++;
        if (u1_rdy !== 4'b0100) $display("FAIL release_rdy: got %0h want 4", u1_rdy); else n_pass++;
        @(posedge clk); #1;
        n_chk += 2;
        if (u1_chan !== 2'd2) $display("FAIL release_chan: got %0d want 2", u1_chan); else n_pass++;
        if (u1_data !== 8'h12) $display("FAIL release_data: got %0h want 12", u1_data); else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_pre();
            n_chk += 2;
            if (u0_rdy !== e_rdy0) begin errs++; $display("FAIL rnd_rdy0[%0d]: got %0h want %0h", k, u0_rdy, e_rdy0); end else n_pass++;
            if (u1_rdy !== e_rdy1) begin errs++; $display("FAIL rnd_rdy1[%0d]: got %0h want %0h", k, u1_rdy, e_rdy1); end else n_pass++;
            @(posedge clk);
            model_clk();
            #1;
            n_chk += 6;
            if (u0_vld !== m0_v) begin errs++; $display("FAIL rnd_vld0[%0d]: got %0h want %0h", k, u0_vld, m0_v); end else n_pass++;
            if (u0_data !== m0_d) begin errs++; $display("FAIL rnd_data0[%0d]: got %0h want %0h", k, u0_data, m0_d); end else n_pass++;
            if (u0_chan !== 2'(m0_c)) begin errs++; $display("FAIL rnd_chan0[%0d]: got %0d want %0d", k, u0_chan, m0_c); end else n_pass++;
            if (u1_vld !== m1_v) begin errs++; $display("FAIL rnd_vld1[%0d]: got %0h want %0h", k, u1_vld, m1_v); end else n_pass++;
            if (u1_data !== m1_d) begin errs++; $display("FAIL rnd_data1[%0d]: got %0h want %0h", k, u1_data, m1_d); end else n_pass++;
            if (u1_chan !== 2'(m1_c)) begin errs++; $display("FAIL rnd_chan1[%0d]: got %0d want %0d", k, u1_chan, m1_c); end else n_pass++;
            if (errs > 20) break;
        end
    endtask

`ifdef Y_MUX_CNT_EN
    task automatic test_counter();
        do_reset();
        sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1; cs0 = 2'd0; cs1 = 2'd0; cs2 = 2'd3;
        repeat (5) @(posedge clk);
        #1;
        n_chk += 2;
        if (cnt0 !== 16'd5) $display("FAIL cnt_early: got %0d want 5", cnt0); else n_pass++;
        if (cnt2 !== 16'd0) $display("FAIL cnt_oob: got %0h want 0", cnt2); else n_pass++;
        repeat (69995) @(posedge clk);
        #1;
        n_chk += 2;
        if (cnt0 !== 16'hFFFF) $display("FAIL cnt_sat0: got %0h want ffff", cnt0); else n_pass++;
        if (cnt1 !== 16'hFFFF) $display("FAIL cnt_sat1: got %0h want ffff", cnt1); else n_pass++;
        cs0 = 2'd1;
        #1;
        n_chk++;
        if (cnt0 !== 16'd0) $display("FAIL cnt_ch1: got %0h want 0", cnt0); else n_pass++;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_stall();
        test_random();
`ifdef Y_MUX_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
